// File: rtl/mips_trace_fifo_pkg.sv
// Shared definitions for the MIPS retire-trace recorder: record kinds,
// field widths and the packed layout of one trace record (timestamp excluded,
// since its width is a per-instance parameter).
package mips_trace_fifo_pkg;

    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_GRF  = 2'b01,
        KIND_DM   = 2'b10
    } trace_kind_e;

    localparam int PC_W   = 32;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Fixed part of a record; the timestamp is appended below it in storage.
    localparam int FIX_W = 2 + PC_W + ADDR_W + DATA_W;

    typedef struct packed {
        trace_kind_e         kind;
        logic [PC_W-1:0]     pc;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
    } trace_rec_t;

    function automatic trace_rec_t make_rec(trace_kind_e kind, logic [PC_W-1:0] pc,
                                            logic [ADDR_W-1:0] addr, logic [DATA_W-1:0] data);
        trace_rec_t r;
        r.kind = kind;
        r.pc   = pc;
        r.addr = addr;
        r.data = data;
        return r;
    endfunction

    // GRF records carry the register index zero-extended into the address field.
    function automatic logic [ADDR_W-1:0] grf_index_addr(logic [REG_W-1:0] idx);
        return {27'd0, idx};
    endfunction

endpackage

// File: rtl/mips_trace_fifo_if.sv
// Drain port of the trace recorder: first-word-fall-through valid/ready
// stream of trace records. The recorder is the master, the consumer the slave.
interface mips_trace_fifo_if #(
    parameter int TS_W = 32
);
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_kind;
    logic [31:0]     out_pc;
    logic [31:0]     out_addr;
    logic [31:0]     out_data;
    logic [TS_W-1:0] out_ts;

    modport master (
        output out_valid, out_kind, out_pc, out_addr, out_data, out_ts,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_kind, out_pc, out_addr, out_data, out_ts,
        output out_ready
    );
endinterface

// File: rtl/mips_trace_fifo_mem.sv
// Record storage for the trace FIFO: DEPTH x W array with two synchronous
// write ports (the controller never drives both to the same address) and one
// asynchronous read port feeding the fall-through head.
module trace_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 130
) (
    input  logic                     clk,
    input  logic                     we0,
    input  logic [$clog2(DEPTH)-1:0] waddr0,
    input  logic [W-1:0]             wdata0,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] waddr1,
    input  logic [W-1:0]             wdata1,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem_r [DEPTH];

    // Write up to two records per cycle into distinct slots.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem_r[waddr0] <= wdata0;
        end
        if (we1) begin
            mem_r[waddr1] <= wdata1;
        end
    end

    assign rdata = mem_r[raddr];
endmodule

// File: rtl/mips_trace_fifo.sv
// Retire-trace recorder: captures up to two architectural write events per
// cycle (GRF write first, then DM store) with PC and cycle timestamp into a
// circular FIFO, drained through a fall-through valid/ready port. Events that
// find no room are counted in a saturating drop counter and flag a sticky
// overflow bit.
module mips_trace_fifo
    import mips_trace_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int TS_W      = 32,
    parameter int DROP_ZERO = 1,
    parameter int DCNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic                     grf_we,
    input  logic [4:0]               grf_addr,
    input  logic [31:0]              grf_data,
    input  logic                     dm_we,
    input  logic [31:0]              dm_addr,
    input  logic [31:0]              dm_data,
    mips_trace_fifo_if.master        drain,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DCNT_W-1:0]        drop_cnt,
    output logic                     overflow
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = FIX_W + TS_W;
    localparam int DW1   = DCNT_W + 1;
    localparam bit FILTER_X0 = (DROP_ZERO != 0);

    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic [TS_W-1:0]   ts_r;
    logic [DCNT_W-1:0] drop_cnt_r;
    logic              overflow_r;

    logic              grf_ev_s;
    logic              dm_ev_s;
    logic [CW-1:0]     free_s;
    logic              push0_s;
    logic              push1_s;
    logic [1:0]        drops_s;
    logic              we0_s;
    logic              we1_s;
    logic              pop_s;
    logic [1:0]        drop_inc_s;
    logic [DW1-1:0]    drop_sum_s;
    logic [DCNT_W-1:0] drop_next_s;
    logic [AW-1:0]     waddr1_s;
    logic [REC_W-1:0]  grf_word_s;
    logic [REC_W-1:0]  dm_word_s;
    logic [REC_W-1:0]  wdata0_s;
    logic [REC_W-1:0]  head_word_s;
    trace_rec_t        head_rec_s;

    assign grf_ev_s = in_valid & grf_we & ~(FILTER_X0 & (grf_addr == 5'd0));
    assign dm_ev_s  = in_valid & dm_we;

    // Space is judged on the occupancy at the start of the cycle; a same-cycle
    // pop does not make room for this cycle's pushes.
    assign free_s = CW'(DEPTH) - count_r;

    assign grf_word_s = {make_rec(KIND_GRF, in_pc, grf_index_addr(grf_addr), grf_data), ts_r};
    assign dm_word_s  = {make_rec(KIND_DM, in_pc, dm_addr, dm_data), ts_r};

    // Decide how many of this cycle's events fit and which slot each lands in.
    always_comb begin
        push0_s  = 1'b0;
        push1_s  = 1'b0;
        drops_s  = 2'd0;
        wdata0_s = grf_word_s;
        case ({grf_ev_s, dm_ev_s})
            2'b11: begin
                if (free_s >= CW'(2)) begin
                    push0_s = 1'b1;
                    push1_s = 1'b1;
                end else if (free_s == CW'(1)) begin
                    push0_s = 1'b1;
                    drops_s = 2'd1;
                end else begin
                    drops_s = 2'd2;
                end
            end
            2'b10: begin
                if (free_s != CW'(0)) begin
                    push0_s = 1'b1;
                end else begin
                    drops_s = 2'd1;
                end
            end
            2'b01: begin
                wdata0_s = dm_word_s;
                if (free_s != CW'(0)) begin
                    push0_s = 1'b1;
                end else begin
                    drops_s = 2'd1;
                end
            end
            default: begin
                push0_s = 1'b0;
            end
        endcase
    end

    // A flush discards same-cycle events outright; they are not drops.
    assign we0_s      = push0_s & ~flush & ~reset;
    assign we1_s      = push1_s & ~flush & ~reset;
    assign drop_inc_s = flush ? 2'd0 : drops_s;
    assign pop_s      = (count_r != CW'(0)) & drain.out_ready;
    assign waddr1_s   = wr_ptr_r + AW'(1);
    assign drop_sum_s = {1'b0, drop_cnt_r} + DW1'(drop_inc_s);

    // Saturating drop counter update.
    always_comb begin
        if (drop_sum_s[DCNT_W]) begin
            drop_next_s = {DCNT_W{1'b1}};
        end else begin
            drop_next_s = drop_sum_s[DCNT_W-1:0];
        end
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_mem (
        .clk    (clk),
        .we0    (we0_s),
        .waddr0 (wr_ptr_r),
        .wdata0 (wdata0_s),
        .we1    (we1_s),
        .waddr1 (waddr1_s),
        .wdata1 (dm_word_s),
        .raddr  (rd_ptr_r),
        .rdata  (head_word_s)
    );

    // Occupancy, pointers, timestamp and drop accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            ts_r       <= '0;
            drop_cnt_r <= '0;
            overflow_r <= 1'b0;
        end else begin
            ts_r       <= ts_r + TS_W'(1);
            drop_cnt_r <= drop_next_s;
            overflow_r <= overflow_r | (drop_inc_s != 2'd0);
            if (flush) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                count_r  <= '0;
            end else begin
                wr_ptr_r <= wr_ptr_r + AW'(we0_s) + AW'(we1_s);
                rd_ptr_r <= rd_ptr_r + AW'(pop_s);
                count_r  <= count_r + CW'(we0_s) + CW'(we1_s) - CW'(pop_s);
            end
        end
    end

    assign head_rec_s = head_word_s[REC_W-1:TS_W];

    // Fall-through head presentation; all fields read as zero when empty.
    always_comb begin
        if (count_r != CW'(0)) begin
            drain.out_valid = 1'b1;
            drain.out_kind  = head_rec_s.kind;
            drain.out_pc    = head_rec_s.pc;
            drain.out_addr  = head_rec_s.addr;
            drain.out_data  = head_rec_s.data;
            drain.out_ts    = head_word_s[TS_W-1:0];
        end else begin
            drain.out_valid = 1'b0;
            drain.out_kind  = 2'b00;
            drain.out_pc    = 32'd0;
            drain.out_addr  = 32'd0;
            drain.out_data  = 32'd0;
            drain.out_ts    = '0;
        end
    end

    assign count    = count_r;
    assign drop_cnt = drop_cnt_r;
    assign overflow = overflow_r;
endmodule

// File: tb/tb_mips_trace_fifo.sv
// Self-checking bench for mips_trace_fifo: a queue-based model of the trace
// recorder is advanced on every clock edge and compared against the DUT on
// every falling edge, plus directed scenarios with literal expectations.
module tb_mips_trace_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, grf_we, dm_we, out_ready;
    logic [31:0] in_pc, grf_data, dm_addr, dm_data;
    logic [4:0]  grf_addr;
    logic [4:0]  count0, count1;
    logic [15:0] drop0, drop1;
    logic        ovf0, ovf1;

    mips_trace_fifo_if #(.TS_W(32)) drain0 ();
    mips_trace_fifo_if #(.TS_W(32)) drain1 ();
    assign drain0.out_ready = out_ready;
    assign drain1.out_ready = out_ready;

    mips_trace_fifo #(.DEPTH(DEPTH), .TS_W(32), .DROP_ZERO(1), .DCNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_data(grf_data),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_data(dm_data),
        .drain(drain0), .count(count0), .drop_cnt(drop0), .overflow(ovf0));

    // Same inputs, x0 writes kept: only examined in the x0 scenario.
    mips_trace_fifo #(.DEPTH(DEPTH), .TS_W(32), .DROP_ZERO(0), .DCNT_W(16)) dut_nz (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_data(grf_data),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_data(dm_data),
        .drain(drain1), .count(count1), .drop_cnt(drop1), .overflow(ovf1));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] ts;
    } rec_t;

    rec_t        q[$];
    logic [31:0] m_ts;
    int          m_drop;
    bit          m_ovf;
    bit          cmp_en = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model of one clock edge, using the model state as it was before the edge.
    task automatic model_edge();
        int   free;
        int   drops;
        bit   pop;
        rec_t r;
        if (reset) begin
            q.delete();
            m_ts = 32'd0;
            m_drop = 0;
            m_ovf = 1'b0;
        end else begin
            free  = DEPTH - q.size();
            drops = 0;
            pop   = (q.size() != 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (in_valid && grf_we && grf_addr != 5'd0) begin
                    if (free > 0) begin
                        r = '{2'b01, in_pc, {27'd0, grf_addr}, grf_data, m_ts};
                        q.push_back(r);
                        free--;
                    end else drops++;
                end
                if (in_valid && dm_we) begin
                    if (free > 0) begin
                        r = '{2'b10, in_pc, dm_addr, dm_data, m_ts};
                        q.push_back(r);
                        free--;
                    end else drops++;
                end
            end
            m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
            if (drops > 0) m_ovf = 1'b1;
            m_ts = m_ts + 32'd1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; in_valid = 1'b0; grf_we = 1'b0; dm_we = 1'b0;
        in_pc = 32'd0; grf_addr = 5'd0; grf_data = 32'd0; dm_addr = 32'd0; dm_data = 32'd0;
    endtask

    task automatic ev(input bit g, input logic [4:0] ga, input logic [31:0] gd,
                      input bit d, input logic [31:0] da, input logic [31:0] dd,
                      input logic [31:0] pc);
        in_valid = 1'b1; grf_we = g; grf_addr = ga; grf_data = gd;
        dm_we = d; dm_addr = da; dm_data = dd; in_pc = pc;
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("count", 64'(count0), 64'(q.size()));
            chk("out_valid", 64'(drain0.out_valid), 64'(q.size() != 0));
            chk("drop_cnt", 64'(drop0), 64'(m_drop));
            chk("overflow", 64'(ovf0), 64'(m_ovf));
            if (q.size() != 0) begin
                chk("out_kind", 64'(drain0.out_kind), 64'(q[0].kind));
                chk("out_pc", 64'(drain0.out_pc), 64'(q[0].pc));
                chk("out_addr", 64'(drain0.out_addr), 64'(q[0].addr));
                chk("out_data", 64'(drain0.out_data), 64'(q[0].data));
                chk("out_ts", 64'(drain0.out_ts), 64'(q[0].ts));
            end else begin
                chk("empty_fields", {30'd0, drain0.out_kind, drain0.out_pc},  64'd0);
                chk("empty_addr_data", {drain0.out_addr, drain0.out_data}, 64'd0);
                chk("empty_ts", 64'(drain0.out_ts), 64'd0);
            end
        end
    end

    initial begin
        int drop_save;
        int ready_pct;
        idle();
        out_ready = 1'b0;

        // Reset held two cycles with write activity present.
        reset = 1'b1;
        ev(1'b1, 5'd3, 32'hDEAD, 1'b1, 32'h40, 32'h1, 32'h3000);
        step();
        cmp_en = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_count", 64'(count0), 64'd0);
        chk("rst_valid", 64'(drain0.out_valid), 64'd0);
        chk("rst_drop", 64'(drop0), 64'd0);
        chk("rst_ovf", 64'(ovf0), 64'd0);

        // Single GRF write in the first cycle after reset: ts 0.
        ev(1'b1, 5'd8, 32'h1234, 1'b0, 32'd0, 32'd0, 32'h3000);
        step();
        idle();
        chk("single_valid", 64'(drain0.out_valid), 64'd1);
        chk("single_kind", 64'(drain0.out_kind), 64'd1);
        chk("single_pc", 64'(drain0.out_pc), 64'h3000);
        chk("single_addr", 64'(drain0.out_addr), 64'd8);
        chk("single_data", 64'(drain0.out_data), 64'h1234);
        chk("single_ts", 64'(drain0.out_ts), 64'd0);
        out_ready = 1'b1;
        step();
        chk("single_popped", 64'(drain0.out_valid), 64'd0);

        // Dual event in one cycle (ts 2): GRF entry ahead of DM entry.
        out_ready = 1'b0;
        ev(1'b1, 5'd9, 32'd5, 1'b1, 32'h10, 32'd7, 32'h3004);
        step();
        idle();
        chk("dual_count", 64'(count0), 64'd2);
        chk("dual_kind0", 64'(drain0.out_kind), 64'd1);
        chk("dual_ts0", 64'(drain0.out_ts), 64'd2);
        out_ready = 1'b1;
        step();
        chk("dual_kind1", 64'(drain0.out_kind), 64'd2);
        chk("dual_addr1", 64'(drain0.out_addr), 64'h10);
        chk("dual_data1", 64'(drain0.out_data), 64'd7);
        chk("dual_ts1", 64'(drain0.out_ts), 64'd2);
        step();

        // Writes to $0: filtered by the default instance, kept by the other.
        out_ready = 1'b0;
        ev(1'b1, 5'd0, 32'hABCD, 1'b0, 32'd0, 32'd0, 32'h3008);
        step();
        idle();
        chk("x0_count", 64'(count0), 64'd0);
        chk("x0_drop", 64'(drop0), 64'd0);
        chk("x0_keep_count", 64'(count1), 64'd1);
        chk("x0_keep_kind", 64'(drain1.out_kind), 64'd1);
        chk("x0_keep_addr", 64'(drain1.out_addr), 64'd0);
        chk("x0_keep_data", 64'(drain1.out_data), 64'hABCD);

        // Overflow: 17 single stores with the consumer stalled.
        for (int i = 0; i < 17; i++) begin
            ev(1'b0, 5'd0, 32'd0, 1'b1, 32'(i * 4), 32'(i + 100), 32'(32'h4000 + i * 4));
            step();
        end
        idle();
        chk("ovf_count", 64'(count0), 64'd16);
        chk("ovf_drop", 64'(drop0), 64'd1);
        chk("ovf_flag", 64'(ovf0), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ovf_count15", 64'(count0), 64'd15);
        ev(1'b1, 5'd12, 32'h55, 1'b1, 32'h80, 32'h66, 32'h5000);
        step();
        idle();
        chk("ovf_dual_count", 64'(count0), 64'd16);
        chk("ovf_dual_drop", 64'(drop0), 64'd2);
        out_ready = 1'b1;
        repeat (17) step();
        chk("drained", 64'(count0), 64'd0);

        // Randomized traffic with varying consumer throughput and rare flushes.
        for (int ph = 0; ph < 8; ph++) begin
            ready_pct = (ph % 4 == 0) ? 10 : (ph % 4 == 1) ? 90 : (ph % 4 == 2) ? 50 : 30;
            for (int c = 0; c < 50; c++) begin
                flush    = ($urandom_range(0, 49) == 0);
                in_valid = ($urandom_range(0, 3) != 0);
                grf_we   = ($urandom_range(0, 1) != 0);
                dm_we    = ($urandom_range(0, 2) == 0);
                grf_addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
                grf_data = $urandom;
                dm_addr  = $urandom;
                dm_data  = $urandom;
                in_pc    = $urandom;
                out_ready = ($urandom_range(0, 99) < ready_pct);
                step();
            end
        end
        idle();

        // Flush with five entries held and an event in the same cycle.
        out_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            ev(1'b1, 5'(i), 32'(i), 1'b0, 32'd0, 32'd0, 32'(32'h6000 + i * 4));
            step();
        end
        idle();
        chk("flush_pre_count", 64'(count0), 64'd5);
        drop_save = m_drop;
        flush = 1'b1;
        ev(1'b1, 5'd7, 32'h77, 1'b1, 32'h90, 32'h88, 32'h7000);
        step();
        idle();
        chk("flush_count", 64'(count0), 64'd0);
        chk("flush_valid", 64'(drain0.out_valid), 64'd0);
        chk("flush_drop", 64'(drop0), 64'(drop_save));
        ev(1'b1, 5'd2, 32'h99, 1'b0, 32'd0, 32'd0, 32'h7004);
        step();
        idle();
        chk("post_flush_count", 64'(count0), 64'd1);
        out_ready = 1'b1;
        repeat (3) step();

        @(posedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
